// File: rtl/id_ex_stage_if.sv
// Bundle of every signal between the ID/EX pipeline register and its neighbours:
// the ID handshake, register-file read port, MEM/WB bypass taps and the EX payload.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [ADDR_WIDTH-1:0] rs1_i;
    logic [ADDR_WIDTH-1:0] rs2_i;
    logic [ADDR_WIDTH-1:0] rd_i;
    logic                  use_rs1_i;
    logic                  use_rs2_i;
    logic                  we_i;
    logic                  is_load_i;
    logic [3:0]            alu_op_i;

    logic [ADDR_WIDTH-1:0] rf_ra_o;
    logic [ADDR_WIDTH-1:0] rf_rb_o;
    logic [DATA_WIDTH-1:0] rf_data_a_i;
    logic [DATA_WIDTH-1:0] rf_data_b_i;

    logic                  mem_we_i;
    logic [ADDR_WIDTH-1:0] mem_rd_i;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_pend_i;
    logic                  wb_we_i;
    logic [ADDR_WIDTH-1:0] wb_rd_i;
    logic [DATA_WIDTH-1:0] wb_data_i;

    logic                  ex_ready_i;
    logic                  flush_i;

    logic                  valid_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] op_a_o;
    logic [DATA_WIDTH-1:0] op_b_o;
    logic [DATA_WIDTH-1:0] imm_o;
    logic [ADDR_WIDTH-1:0] rd_o;
    logic                  we_o;
    logic                  is_load_o;
    logic [3:0]            alu_op_o;

    modport slave (
        input  valid_i, pc_i, imm_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i,
               we_i, is_load_i, alu_op_i, rf_data_a_i, rf_data_b_i,
               mem_we_i, mem_rd_i, mem_data_i, mem_pend_i,
               wb_we_i, wb_rd_i, wb_data_i, ex_ready_i, flush_i,
        output ready_o, rf_ra_o, rf_rb_o, valid_o, pc_o, op_a_o, op_b_o,
               imm_o, rd_o, we_o, is_load_o, alu_op_o
    );

    modport master (
        output valid_i, pc_i, imm_i, rs1_i, rs2_i, rd_i, use_rs1_i, use_rs2_i,
               we_i, is_load_i, alu_op_i, rf_data_a_i, rf_data_b_i,
               mem_we_i, mem_rd_i, mem_data_i, mem_pend_i,
               wb_we_i, wb_rd_i, wb_data_i, ex_ready_i, flush_i,
        input  ready_o, rf_ra_o, rf_rb_o, valid_o, pc_o, op_a_o, op_b_o,
               imm_o, rd_o, we_o, is_load_o, alu_op_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operands with MEM-over-WB bypass, detects
// load-use and EX-dependency hazards, and inserts bubbles or holds on EX backpressure.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    id_ex_stage_if.slave  bus
);

    // x0 is hard zero: never bypassed, even if a producer claims to write it.
    function automatic logic [DATA_WIDTH-1:0] resolve(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  mem_we,
        input logic [ADDR_WIDTH-1:0] mem_rd,
        input logic [DATA_WIDTH-1:0] mem_data,
        input logic                  wb_we,
        input logic [ADDR_WIDTH-1:0] wb_rd,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] res;
        res = rf_data;
        if (rs == '0)
            res = '0;
        else if (mem_we && (mem_rd == rs))
            res = mem_data;
        else if (wb_we && (wb_rd == rs))
            res = wb_data;
        return res;
    endfunction

    logic                  valid_q,   valid_d;
    logic [DATA_WIDTH-1:0] pc_q,      pc_d;
    logic [DATA_WIDTH-1:0] imm_q,     imm_d;
    logic [DATA_WIDTH-1:0] op_a_q,    op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q,    op_b_d;
    logic [ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic                  we_q,      we_d;
    logic                  is_load_q, is_load_d;
    logic [3:0]            alu_op_q,  alu_op_d;

    logic [DATA_WIDTH-1:0] op_a_res, op_b_res;
    logic                  rs1_live, rs2_live;
    logic                  ex_hazard, mem_hazard, hazard;
    logic                  advance, take;

    always_comb begin
        op_a_res = resolve(bus.rs1_i, bus.rf_data_a_i, bus.mem_we_i, bus.mem_rd_i,
                           bus.mem_data_i, bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i);
        op_b_res = resolve(bus.rs2_i, bus.rf_data_b_i, bus.mem_we_i, bus.mem_rd_i,
                           bus.mem_data_i, bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i);
    end

    always_comb begin
        rs1_live   = bus.use_rs1_i && (bus.rs1_i != '0);
        rs2_live   = bus.use_rs2_i && (bus.rs2_i != '0);
        ex_hazard  = valid_q && we_q && (rd_q != '0) && bus.valid_i &&
                     ((rs1_live && (bus.rs1_i == rd_q)) ||
                      (rs2_live && (bus.rs2_i == rd_q)));
        // A pending MEM value cannot be bypassed yet, so the consumer must wait.
        mem_hazard = bus.mem_we_i && bus.mem_pend_i &&
                     ((rs1_live && (bus.rs1_i == bus.mem_rd_i)) ||
                      (rs2_live && (bus.rs2_i == bus.mem_rd_i)));
        hazard     = (ex_hazard || mem_hazard) && !bus.flush_i;
        advance    = bus.ex_ready_i || !valid_q;
        take       = bus.valid_i && advance && !hazard && !bus.flush_i;
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_d      = rd_q;
        we_d      = we_q;
        is_load_d = is_load_q;
        alu_op_d  = alu_op_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = take;
            if (take) begin
                pc_d      = bus.pc_i;
                imm_d     = bus.imm_i;
                op_a_d    = op_a_res;
                op_b_d    = op_b_res;
                rd_d      = bus.rd_i;
                we_d      = bus.we_i;
                is_load_d = bus.is_load_i;
                alu_op_d  = bus.alu_op_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            alu_op_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            is_load_q <= is_load_d;
            alu_op_q  <= alu_op_d;
        end
    end

    // Flush must always drain ID, whatever the hazard or backpressure state.
    assign bus.ready_o   = bus.flush_i || (advance && !hazard);
    assign bus.rf_ra_o   = bus.rs1_i;
    assign bus.rf_rb_o   = bus.rs2_i;
    assign bus.valid_o   = valid_q;
    assign bus.pc_o      = pc_q;
    assign bus.imm_o     = imm_q;
    assign bus.op_a_o    = op_a_q;
    assign bus.op_b_o    = op_b_q;
    assign bus.rd_o      = rd_q;
    assign bus.we_o      = we_q;
    assign bus.is_load_o = is_load_q;
    assign bus.alu_op_o  = alu_op_q;

endmodule
